// File: rtl/rp_link_master_if.sv
// Signal bundle between rp_link_master and its surroundings: GPIO link to the ISA card plus
// the RP-side rx/sector/audio/port streams and the busy flag.
interface rp_link_master_if;
    logic        fpga_tx_req;
    logic        fpga_rx_req;
    logic [8:0]  link_do;
    logic        link_clock;
    logic [2:0]  link_state;
    logic [7:0]  link_di;
    logic [8:0]  rx_word;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  sec_data;
    logic        sec_valid;
    logic        sec_ready;
    logic [15:0] aud_r;
    logic [15:0] aud_l;
    logic        aud_valid;
    logic        aud_ready;
    logic [7:0]  port_id;
    logic [23:0] port_data;
    logic        port_valid;
    logic        port_ready;
    logic        busy;

    modport master (
        input  fpga_tx_req, fpga_rx_req, link_do, rx_ready, sec_data, sec_valid,
               aud_r, aud_l, aud_valid, port_id, port_data, port_valid,
        output link_clock, link_state, link_di, rx_word, rx_valid, sec_ready,
               aud_ready, port_ready, busy
    );

    modport slave (
        output fpga_tx_req, fpga_rx_req, link_do, rx_ready, sec_data, sec_valid,
               aud_r, aud_l, aud_valid, port_id, port_data, port_valid,
        input  link_clock, link_state, link_di, rx_word, rx_valid, sec_ready,
               aud_ready, port_ready, busy
    );
endinterface

// File: rtl/rp_link_master.sv
// Host-side master of the FPGA<->RP GPIO link: drives CLOCK/STATE and moves words/bytes both ways.
// Define RPLINK_PORT_EN to enable the 4-byte PORT (mouse) channel.
module rp_link_master #(
    parameter int unsigned HALF    = 16,
    parameter int unsigned HOLD    = 4,
    parameter int unsigned SEC_LEN = 512
) (
    input logic              clk,
    input logic              rst_n,
    rp_link_master_if.master link
);
    localparam int unsigned CW = $clog2(HALF);
    localparam int unsigned SW = $clog2(SEC_LEN);
    localparam logic [CW-1:0] CntEdge = CW'(HALF - 1);
    localparam logic [CW-1:0] CntData = CW'(HOLD - 1);
    localparam logic [CW-1:0] CntSamp = CW'(HALF - 1 - HOLD);
    localparam logic [SW-1:0] SecLast = SW'(SEC_LEN - 1);

    // Encodings double as the STATE[2:0] code on the link.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRead   = 3'd1,
        StPort   = 3'd2,
        StAudio  = 3'd3,
        StSector = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic [2:0]    idx_q, idx_d;
    logic [SW-1:0] sec_cnt_q, sec_cnt_d;
    logic [31:0]   di_q, di_d;
    logic          tx_s_q, tx_s_d;
    logic [8:0]    rx_word_q, rx_word_d;
    logic          rx_valid_q, rx_valid_d;
    logic          sec_ready_q, sec_ready_d;
    logic          aud_ready_q, aud_ready_d;
    logic          edge_now, data_now;
`ifdef RPLINK_PORT_EN
    logic          port_ready_q, port_ready_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CntEdge) ? '0 : cnt_q + 1'b1;
        clk_d       = clk_q;
        idx_d       = idx_q;
        sec_cnt_d   = sec_cnt_q;
        di_d        = di_q;
        tx_s_d      = tx_s_q;
        rx_word_d   = rx_word_q;
        rx_valid_d  = rx_valid_q;
        sec_ready_d = 1'b0;
        aud_ready_d = 1'b0;
`ifdef RPLINK_PORT_EN
        port_ready_d = 1'b0;
`endif
        edge_now = (cnt_q == CntEdge);
        data_now = (cnt_q == CntData);

        if (rx_valid_q && link.rx_ready) rx_valid_d = 1'b0;
        if (state_q == StIdle && clk_q && cnt_q == CntSamp) tx_s_d = link.fpga_tx_req;

        if (edge_now) begin
            clk_d = ~clk_q;
            idx_d = idx_q + 3'd1;
            case (state_q)
                StRead: if (clk_q) begin
                    rx_word_d  = link.link_do;
                    rx_valid_d = 1'b1;
                end
                StAudio: if (idx_q == 3'd5) aud_ready_d = 1'b1;
`ifdef RPLINK_PORT_EN
                StPort: if (idx_q == 3'd3) port_ready_d = 1'b1;
`endif
                default: ;
            endcase
        end

        if (data_now) begin
            case (state_q)
                StIdle: if (idx_q == 3'd2) begin
                    // Arbitration only after a complete idle period.
                    idx_d = '0;
                    if (tx_s_q && !rx_valid_q) begin
                        state_d = StRead;
                        di_d    = '0;
                    end else if (link.fpga_rx_req && link.aud_valid) begin
                        state_d = StAudio;
                        di_d    = {link.aud_r, link.aud_l};
                    end else if (link.sec_valid) begin
                        state_d     = StSector;
                        di_d        = {link.sec_data, 24'h0};
                        sec_ready_d = 1'b1;
                        sec_cnt_d   = SW'(1);
`ifdef RPLINK_PORT_EN
                    end else if (link.port_valid) begin
                        state_d = StPort;
                        di_d    = {link.port_id, link.port_data};
`endif
                    end
                end
                StRead: if (idx_q == 3'd2) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
                StAudio: begin
                    if (idx_q == 3'd6) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        di_d    = '0;
                    end else begin
                        di_d = {di_q[23:0], 8'h00};
                    end
                end
`ifdef RPLINK_PORT_EN
                StPort: begin
                    if (idx_q == 3'd4) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        di_d    = '0;
                    end else begin
                        di_d = {di_q[23:0], 8'h00};
                    end
                end
`endif
                StSector: if (!clk_q) begin
                    if (sec_cnt_q == '0) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        di_d    = '0;
                    end else if (link.sec_valid) begin
                        di_d        = {link.sec_data, 24'h0};
                        sec_ready_d = 1'b1;
                        sec_cnt_d   = (sec_cnt_q == SecLast) ? '0 : sec_cnt_q + 1'b1;
                    end else begin
                        // Starved: park CLOCK low until the next byte arrives.
                        cnt_d = cnt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            clk_q       <= 1'b0;
            idx_q       <= '0;
            sec_cnt_q   <= '0;
            di_q        <= '0;
            tx_s_q      <= 1'b0;
            rx_word_q   <= '0;
            rx_valid_q  <= 1'b0;
            sec_ready_q <= 1'b0;
            aud_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_q       <= clk_d;
            idx_q       <= idx_d;
            sec_cnt_q   <= sec_cnt_d;
            di_q        <= di_d;
            tx_s_q      <= tx_s_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            sec_ready_q <= sec_ready_d;
            aud_ready_q <= aud_ready_d;
        end
    end

`ifdef RPLINK_PORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) port_ready_q <= 1'b0;
        else        port_ready_q <= port_ready_d;
    end
    assign link.port_ready = port_ready_q;
`else
    assign link.port_ready = 1'b0;
`endif

    assign link.link_clock = clk_q;
    assign link.link_state = state_q;
    assign link.link_di    = di_q[31:24];
    assign link.rx_word    = rx_word_q;
    assign link.rx_valid   = rx_valid_q;
    assign link.sec_ready  = sec_ready_q;
    assign link.aud_ready  = aud_ready_q;
    assign link.busy       = (state_q != StIdle);
endmodule
